// File: rtl/present_pkg.sv
// Shared PRESENT-80 definitions: widths, round count, S-box and pLayer helpers.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package present_pkg;

  localparam int NUM_ROUNDS  = 31;
  localparam int BLOCK_WIDTH = 64;
  localparam int KEY_WIDTH   = 80;

  // 4-bit PRESENT S-box.
  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hC;
      4'h1: y = 4'h5;
      4'h2: y = 4'h6;
      4'h3: y = 4'hB;
      4'h4: y = 4'h9;
      4'h5: y = 4'h0;
      4'h6: y = 4'hA;
      4'h7: y = 4'hD;
      4'h8: y = 4'h3;
      4'h9: y = 4'hE;
      4'hA: y = 4'hF;
      4'hB: y = 4'h8;
      4'hC: y = 4'h4;
      4'hD: y = 4'h7;
      4'hE: y = 4'h1;
      default: y = 4'h2;
    endcase
    return y;
  endfunction

  // S-box applied to all 16 nibbles of the state.
  function automatic logic [BLOCK_WIDTH-1:0] sbox_layer(input logic [BLOCK_WIDTH-1:0] x);
    logic [BLOCK_WIDTH-1:0] y;
    y = '0;
    for (int n = 0; n < BLOCK_WIDTH / 4; n++) begin
      y[4*n +: 4] = sbox(x[4*n +: 4]);
    end
    return y;
  endfunction

  // pLayer: bit i moves to (16*i) mod 63; bit 63 stays in place.
  function automatic logic [BLOCK_WIDTH-1:0] player(input logic [BLOCK_WIDTH-1:0] x);
    logic [BLOCK_WIDTH-1:0] y;
    y = '0;
    for (int i = 0; i < BLOCK_WIDTH - 1; i++) begin
      y[(16 * i) % 63] = x[i];
    end
    y[BLOCK_WIDTH-1] = x[BLOCK_WIDTH-1];
    return y;
  endfunction

endpackage

// File: rtl/present_key_schedule.sv
// PRESENT-80 key update: rotate left 61, S-box on top nibble, xor round counter.
// Latency: combinational, zero cycles.
// Backpressure: none; output follows inputs.
// Ports: masterkey_i (current round key register), round_i (5-bit round
// counter), next_key_o (key register value for the following round).
module present_key_schedule
  import present_pkg::*;
(
  input  logic [KEY_WIDTH-1:0] masterkey_i,
  input  logic [4:0]           round_i,
  output logic [KEY_WIDTH-1:0] next_key_o
);

  logic [KEY_WIDTH-1:0] k;

  always_comb begin
    k          = {masterkey_i[18:0], masterkey_i[79:19]};
    k[79:76]   = sbox(k[79:76]);
    k[19:15]   = k[19:15] ^ round_i;
    next_key_o = k;
  end

endmodule

// File: rtl/present80_encrypt.sv
// Iterative PRESENT-80 encryption, one round per clock, operands loaded under reset.
// Latency: ready rises on the 31st rising edge after the last reset edge.
// Backpressure: none; result is held until the next reset.
// Ports: clk, reset (sync, active-high, loads operands), plaintext[63:0],
// key[79:0], ready (ciphertext valid), ciphertext[63:0].
module present80_encrypt
  import present_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic [BLOCK_WIDTH-1:0] plaintext,
  input  logic [KEY_WIDTH-1:0]   key,
  output logic                   ready,
  output logic [BLOCK_WIDTH-1:0] ciphertext
);

  logic [BLOCK_WIDTH-1:0] data_q, data_d;
  logic [KEY_WIDTH-1:0]   key_q, key_d;
  logic [5:0]             round_q, round_d;
  logic                   ready_q, ready_d;
  logic [BLOCK_WIDTH-1:0] ct_q, ct_d;

  logic [BLOCK_WIDTH-1:0] perm_data;
  logic [KEY_WIDTH-1:0]   next_key;

  present_key_schedule u_key_schedule (
    .masterkey_i (key_q),
    .round_i     (round_q[4:0]),
    .next_key_o  (next_key)
  );

  // One full round: addRoundKey, sBoxLayer, pLayer.
  assign perm_data = player(sbox_layer(data_q ^ key_q[79:16]));

  always_comb begin
    data_d  = data_q;
    key_d   = key_q;
    round_d = round_q;
    ready_d = ready_q;
    ct_d    = ct_q;
    if (!ready_q) begin
      data_d  = perm_data;
      key_d   = next_key;
      round_d = round_q + 6'd1;
      // On the last round the next key is K32, used for output whitening.
      if (round_q == 6'(NUM_ROUNDS)) begin
        ct_d    = perm_data ^ next_key[79:16];
        ready_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q  <= plaintext;
      key_q   <= key;
      round_q <= 6'd1;
      ready_q <= 1'b0;
      ct_q    <= '0;
    end else begin
      data_q  <= data_d;
      key_q   <= key_d;
      round_q <= round_d;
      ready_q <= ready_d;
      ct_q    <= ct_d;
    end
  end

  assign ready      = ready_q;
  assign ciphertext = ct_q;

endmodule

// File: tb/tb_present80_encrypt.sv
// Directed testbench for present80_encrypt using published PRESENT-80 vectors.
module tb_present80_encrypt;

  logic        clk;
  logic        reset;
  logic [63:0] plaintext;
  logic [79:0] key;
  logic        ready;
  logic [63:0] ciphertext;

  int total  = 0;
  int passed = 0;

  present80_encrypt dut (
    .clk        (clk),
    .reset      (reset),
    .plaintext  (plaintext),
    .key        (key),
    .ready      (ready),
    .ciphertext (ciphertext)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Reset for one edge with the given operands, then count edges until ready.
  task automatic run(input string tag, input logic [63:0] pt, input logic [79:0] k,
                     input logic [63:0] exp);
    int n;
    plaintext = pt;
    key       = k;
    reset     = 1'b1;
    @(posedge clk); #1;
    chk({tag, "_rst_ready"}, {79'd0, ready}, 80'd0);
    chk({tag, "_rst_ct"}, {16'd0, ciphertext}, 80'd0);
    reset = 1'b0;
    n = 0;
    while (!ready && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_latency"}, 80'(n), 80'd31);
    chk({tag, "_ct"}, {16'd0, ciphertext}, {16'd0, exp});
  endtask

  initial begin
    int n;
    bit stable;
    logic [63:0] held_ct;

    // Vector 1: zero plaintext, zero key, with internal first-round checks.
    plaintext = 64'h0;
    key       = 80'h0;
    reset     = 1'b1;
    @(posedge clk); #1;
    chk("v1_rst_ready", {79'd0, ready}, 80'd0);
    chk("v1_rst_ct", {16'd0, ciphertext}, 80'd0);
    chk("v1_rst_round", {74'd0, dut.round_q}, 80'd1);
    chk("v1_rst_data", {16'd0, dut.data_q}, 80'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    // S(0)=C on every nibble; pLayer sends bits 2 mod 4 to 32..47, 3 mod 4 to 48..63.
    chk("v1_edge1_data", {16'd0, dut.data_q}, {16'd0, 64'hFFFFFFFF00000000});
    chk("v1_edge1_round", {74'd0, dut.round_q}, 80'd2);
    chk("v1_edge1_ready", {79'd0, ready}, 80'd0);
    n = 1;
    while (!ready && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("v1_latency", 80'(n), 80'd31);
    chk("v1_ct", {16'd0, ciphertext}, {16'd0, 64'h5579C1387B228445});

    run("v2", 64'hFFFFFFFFFFFFFFFF, 80'h0, 64'hA112FFC72F68417B);
    run("v3", 64'h0, 80'hFFFFFFFFFFFFFFFFFFFF, 64'hE72C46C0F5945049);
    run("v4", 64'hFFFFFFFFFFFFFFFF, 80'hFFFFFFFFFFFFFFFFFFFF, 64'h3333DCD3213210D2);

    // Done state must ignore operand changes without reset.
    held_ct   = ciphertext;
    stable    = 1'b1;
    plaintext = 64'h0123456789ABCDEF;
    key       = 80'h00112233445566778899;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (!ready || ciphertext !== held_ct) stable = 1'b0;
    end
    chk("hold_stable", {79'd0, stable}, 80'd1);
    chk("hold_ready", {79'd0, ready}, 80'd1);
    chk("hold_ct", {16'd0, ciphertext}, {16'd0, 64'h3333DCD3213210D2});

    // Abort mid-run at round 10 and restart from new operands.
    plaintext = 64'h0;
    key       = 80'h0;
    reset     = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
    end
    chk("abort_round", {74'd0, dut.round_q}, 80'd10);
    run("abort", 64'hFFFFFFFFFFFFFFFF, 80'hFFFFFFFFFFFFFFFFFFFF, 64'h3333DCD3213210D2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
